fp_addsub_seq: RTL and testbench

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

---
 rtl/fp_addsub_seq_pkg.sv | 22 ++
 rtl/fp_addsub_seq_unpack.sv | 18 +
 rtl/fp_addsub_seq.sv | 171 +++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_seq_pkg.sv
// Shared definitions for the sequential single-precision adder/subtractor:
// FSM states, IEEE-754 field constants and the internal significand width.
package fp_addsub_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    PACK
  } state_t;

  localparam int EXP_BIAS  = 127;
  localparam int EXP_MAX   = 255;
  localparam int MANT_W    = 23;
  localparam int EXT_W     = 3;
  localparam int ALIGN_CAP = 26;

  // hidden bit + stored fraction + extension bits
  localparam int SIG_W = MANT_W + 1 + EXT_W;

endpackage

// File: rtl/fp_addsub_seq_unpack.sv
// Splits a single-precision word into sign, exponent and an extended significand,
// flushing denormals to zero and inserting the hidden bit for normal numbers.
module fp_unpack
  import fp_addsub_seq_pkg::*;
(
  input  logic [31:0]      word,
  output logic             sign,
  output logic [7:0]       exp,
  output logic [SIG_W-1:0] mant,
  output logic             is_zero
);

  assign sign    = word[31];
  assign exp     = word[30:23];
  assign is_zero = (word[30:23] == 8'd0);
  assign mant    = is_zero ? '0 : {1'b1, word[MANT_W-1:0], {EXT_W{1'b0}}};

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract with one-bit-per-cycle
// alignment and normalisation, truncating (round-toward-zero) result.
module fp_addsub_seq
  import fp_addsub_seq_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start_i,
  input  logic                 op_i,
  input  logic [DATAWIDTH-1:0] data_iA,
  input  logic [DATAWIDTH-1:0] data_iB,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  state_t state, state_next;

  logic                ua_sign, ub_sign, ua_zero, ub_zero;
  logic [7:0]          ua_exp, ub_exp;
  logic [SIG_W-1:0]    ua_mant, ub_mant;

  logic [7:0]          cap_exp_a, cap_exp_b, exp_diff;
  logic [SIG_W-1:0]    cap_mant_a, cap_mant_b;

  logic                sign_a, sign_b, sign_r;
  logic signed [9:0]   exp_a, exp_b, exp_r;
  logic [SIG_W-1:0]    mant_a, mant_b;
  logic [SIG_W:0]      sum, add_sum;
  logic                add_sign;
  logic [DATAWIDTH-1:0] packed_word;

  fp_unpack u_unpack_a (
    .word    (data_iA),
    .sign    (ua_sign),
    .exp     (ua_exp),
    .mant    (ua_mant),
    .is_zero (ua_zero)
  );

  fp_unpack u_unpack_b (
    .word    (data_iB),
    .sign    (ub_sign),
    .exp     (ub_exp),
    .mant    (ub_mant),
    .is_zero (ub_zero)
  );

  // Pre-cap a huge exponent gap so ALIGN never runs more than ALIGN_CAP shifts;
  // the far-smaller operand then contributes nothing.
  always_comb begin
    cap_exp_a  = ua_zero ? 8'd0 : ua_exp;
    cap_exp_b  = ub_zero ? 8'd0 : ub_exp;
    cap_mant_a = ua_mant;
    cap_mant_b = ub_mant;
    if (cap_exp_a >= cap_exp_b) begin
      exp_diff = cap_exp_a - cap_exp_b;
      if (exp_diff > 8'(ALIGN_CAP)) begin
        cap_exp_b  = cap_exp_a - 8'(ALIGN_CAP);
        cap_mant_b = '0;
      end
    end else begin
      exp_diff = cap_exp_b - cap_exp_a;
      if (exp_diff > 8'(ALIGN_CAP)) begin
        cap_exp_a  = cap_exp_b - 8'(ALIGN_CAP);
        cap_mant_a = '0;
      end
    end
  end

  always_comb begin
    add_sign = sign_a;
    add_sum  = '0;
    if (sign_a == sign_b) begin
      add_sum = {1'b0, mant_a} + {1'b0, mant_b};
    end else if (mant_a >= mant_b) begin
      add_sum = {1'b0, mant_a - mant_b};
    end else begin
      add_sum  = {1'b0, mant_b - mant_a};
      add_sign = sign_b;
    end
    if (add_sum == '0) add_sign = 1'b0;
  end

  always_comb begin
    if (sum == '0) begin
      packed_word = '0;
    end else if (exp_r >= $signed(10'(EXP_MAX))) begin
      packed_word = {sign_r, 8'hFF, {MANT_W{1'b0}}};
    end else if (exp_r <= 10'sd0) begin
      packed_word = {sign_r, {(DATAWIDTH-1){1'b0}}};
    end else begin
      packed_word = {sign_r, exp_r[7:0], sum[SIG_W-2:EXT_W]};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_i) state_next = ALIGN;
      ALIGN: if (exp_a == exp_b) state_next = ADD;
      ADD:   state_next = NORM;
      NORM:  if (!sum[SIG_W] && (sum == '0 || sum[SIG_W-1])) state_next = PACK;
      PACK:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      sign_r <= 1'b0;
      exp_a  <= '0;
      exp_b  <= '0;
      exp_r  <= '0;
      mant_a <= '0;
      mant_b <= '0;
      sum    <= '0;
      data_o <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= (state == PACK);
      case (state)
        IDLE: if (start_i) begin
          sign_a <= ua_sign;
          sign_b <= ub_sign ^ op_i;
          exp_a  <= $signed({2'b00, cap_exp_a});
          exp_b  <= $signed({2'b00, cap_exp_b});
          mant_a <= cap_mant_a;
          mant_b <= cap_mant_b;
        end
        ALIGN: begin
          if (exp_a < exp_b) begin
            mant_a <= mant_a >> 1;
            exp_a  <= exp_a + 10'sd1;
          end else if (exp_a > exp_b) begin
            mant_b <= mant_b >> 1;
            exp_b  <= exp_b + 10'sd1;
          end
        end
        ADD: begin
          sum    <= add_sum;
          sign_r <= add_sign;
          exp_r  <= exp_a;
        end
        NORM: begin
          if (sum[SIG_W]) begin
            sum   <= sum >> 1;
            exp_r <= exp_r + 10'sd1;
          end else if (sum != '0 && !sum[SIG_W-1]) begin
            sum   <= sum << 1;
            exp_r <= exp_r - 10'sd1;
          end
        end
        PACK: data_o <= packed_word;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed table-driven bench for fp_addsub_seq with hand-computed results and
// latencies, plus sequences for busy-ignore, back-to-back and mid-operation reset.
module tb_fp_addsub_seq;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start_i = 1'b0;
  logic        op_i = 1'b0;
  logic [31:0] data_iA = '0;
  logic [31:0] data_iB = '0;
  logic [31:0] data_o;
  logic        busy_o;
  logic        done_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  fp_addsub_seq #(.DATAWIDTH(32)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .start_i (start_i),
    .op_i    (op_i),
    .data_iA (data_iA),
    .data_iB (data_iB),
    .data_o  (data_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // Counts edges after the capture edge until done_o is seen; -1 on timeout.
  task automatic waitDone(output logic [31:0] result, output int lat);
    lat = -1;
    result = '0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge Clk);
      #1;
      if (done_o) begin
        lat = c;
        result = data_o;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op,
                               output logic [31:0] result, output int lat);
    @(negedge Clk);
    data_iA = a;
    data_iB = b;
    op_i = op;
    start_i = 1'b1;
    @(posedge Clk);
    #1 start_i = 1'b0;
    waitDone(result, lat);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;

    vecs[0]  = '{"one_plus_two",  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5};
    vecs[1]  = '{"neg1_plus_two", 32'hBF800000, 32'h40000000, 1'b0, 32'h3F800000, 6};
    vecs[2]  = '{"cancel",        32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4};
    vecs[3]  = '{"overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5};
    vecs[4]  = '{"three_minus_1", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 5};
    vecs[5]  = '{"zero_plus_one", 32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 30};
    vecs[6]  = '{"tiny_truncate", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 28};
    vecs[7]  = '{"carry_rtz",     32'h3F800003, 32'h3F800000, 1'b0, 32'h40000001, 5};
    vecs[8]  = '{"underflow",     32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 5};
    vecs[9]  = '{"neg_neg",       32'hC0000000, 32'hC0000000, 1'b0, 32'hC0800000, 5};
    vecs[10] = '{"long_norm",     32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 27};

    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset_data", data_o, 32'h0);
    checkOutput("reset_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("reset_done", {31'b0, done_o}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, res, lat);
      checkOutput({vecs[i].name, "_data"}, res, vecs[i].exp_data);
      checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput({vecs[i].name, "_idle_at_done"}, {31'b0, busy_o}, 32'h0);
      @(posedge Clk);
      #1;
      checkOutput({vecs[i].name, "_done_pulse"}, {31'b0, done_o}, 32'h0);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge Clk);
    data_iA = 32'h3F800000;
    data_iB = 32'h40000000;
    op_i = 1'b0;
    start_i = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput("busy_after_start", {31'b0, busy_o}, 32'h1);
    data_iA = 32'h40800000;
    data_iB = 32'h40800000;
    @(posedge Clk);
    @(posedge Clk);
    #1 start_i = 1'b0;
    lat = -1;
    res = '0;
    for (int c = 3; c <= 100; c++) begin
      @(posedge Clk);
      #1;
      if (done_o) begin
        lat = c;
        res = data_o;
        break;
      end
    end
    checkOutput("ignore_data", res, 32'h40400000);
    checkOutput("ignore_lat", 32'(lat), 32'd5);
    data_iA = 32'hBF800000;
    data_iB = 32'h40000000;
    op_i = 1'b0;
    start_i = 1'b1;
    @(posedge Clk);
    #1 start_i = 1'b0;
    checkOutput("b2b_busy", {31'b0, busy_o}, 32'h1);
    checkOutput("b2b_hold", data_o, 32'h40400000);
    waitDone(res, lat);
    checkOutput("b2b_data", res, 32'h3F800000);
    checkOutput("b2b_lat", 32'(lat), 32'd6);

    // Reset in the middle of a long ALIGN.
    @(negedge Clk);
    data_iA = 32'h00000000;
    data_iB = 32'h3F800000;
    op_i = 1'b0;
    start_i = 1'b1;
    @(posedge Clk);
    #1 start_i = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    checkOutput("midrst_data", data_o, 32'h0);
    checkOutput("midrst_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("midrst_done", {31'b0, done_o}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(32'h3F800000, 32'hC0000000, 1'b0, res, lat);
    checkOutput("postrst_data", res, 32'hBF800000);
    checkOutput("postrst_lat", 32'(lat), 32'd6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
